mdu_unit: RTL
=============

# mdu_unit

Multi-cycle multiply/divide unit with HI/LO registers, sitting beside the ALU in the EX stage and sharing its A/B operands. It performs MIPS MULT/MULTU/DIV/DIVU and MTHI/MTLO, and presents HI/LO for MFHI/MFLO. The hazard logic reads `busy` and `start` and stalls any MDU-class instruction in the decode stage while the unit is occupied.

## Interface
- MULT_CYCLES, 5, busy cycles for multiply-class ops (range 1..15)
- DIV_CYCLES, 10, busy cycles for divide-class ops (range 1..15)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- A  in  32  operand rs (dividend / multiplicand / MTHI-MTLO source)
- B  in  32  operand rt (divisor / multiplier)
- MDUop  in  4  operation: 0000 none, 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU, 0101 MTHI, 0110 MTLO, 0111 MADD, 1000 MADDU, 1001 MSUB, 1010 MSUBU; others are a no-op
- start  in  1  one-cycle request qualifier for MDUop
- busy  out  1  operation in flight
- HI  out  32  HI register
- LO  out  32  LO register

## Operation
- Request accepted at a rising edge when start=1, busy=0 and MDUop is a valid op; otherwise start is ignored and no state changes.
- start while busy=1: ignored; the in-flight op is unaffected. Hazard logic never issues it.
- MTHI/MTLO: HI<=A or LO<=A at the accepting edge; busy stays 0.
- MULT: signed 32x32->64. MULTU: unsigned. The result is computed from the operands at the accepting edge and held in a pending register. A/B may change afterwards.
- DIV: signed quotient to LO, truncated toward zero; remainder to HI, carrying the dividend's sign. DIVU: unsigned.
- 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0x00000000.
- Divide by zero (B=0): the op runs full latency, and HI/LO are left unchanged at commit.
- State machine IDLE -> BUSY(count) -> IDLE.
  - Accepting a multi-cycle op loads count=N-1 and enters BUSY.
  - count decrements each cycle.
  - At the edge where count=0 in BUSY: {HI,LO}<=pending and the machine returns to IDLE.
- HI/LO outputs show committed values only; pending results are never visible early.

## Timing
- Reset values: busy=0, HI=0, LO=0, pending=0, state IDLE.
- Reset asserted mid-operation aborts the op immediately (asynchronously). No commit occurs after release.
- Accept edge E0 -> busy=1 from E0 until edge EN, where N=MULT_CYCLES or DIV_CYCLES.
- At EN, HI/LO update and busy=0 together.
- busy is high for exactly N cycles.
- A new request may be accepted at EN+1 at the earliest; it cannot be accepted at EN, where busy is still 1 before the edge.
- MTHI/MTLO: 1-cycle write. Visible on HI/LO after E0.
- busy is a pure register output; no combinational path from start to busy. Hazard logic ORs start itself.

## Configuration
- `MDU_MADD_EN` defined:
  - MADD/MADDU/MSUB/MSUBU are supported, with MULT_CYCLES latency.
  - Result is {HI,LO} ± product, using signed or unsigned product per op, 64-bit wrap-around.
  - Accumulation uses the {HI,LO} value at commit time.
- Not defined: opcodes 0111-1010 are no-ops (no busy, no HI/LO change).

## Test plan
- Reset mid-DIV: accept DIVU at E0, assert reset at E3 -> busy=0, HI=LO=0 immediately; no update at E10.
- MULT A=0xFFFFFFFF B=0x00000002 -> busy high 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE. Same operands with MULTU -> HI=0x00000001 LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7) B=0x00000002 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- Busy collision: start MULT, then pulse start with MTLO A=0x1234 at E2 -> MTLO ignored; final HI/LO are the MULT result only. MTLO at EN+1 -> LO=0x1234.
- Divide by zero: HI=0xAAAA0000 LO=0x5555 preset by MTHI/MTLO, then DIV B=0 -> busy 10 cycles, HI/LO unchanged.
- With `MDU_MADD_EN`: MTHI 0, MTLO 0xFFFFFFFF, then MADDU 1x1 -> HI=0x00000001 LO=0x00000000. Without the macro, the same MADDU -> busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_unit.sv
// Multi-cycle MIPS multiply/divide unit with HI/LO registers and MTHI/MTLO.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUop,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    typedef enum logic [1:0] {
        CM_LOAD,
        CM_ADD,
        CM_SUB,
        CM_SKIP
    } commit_e;

    localparam logic [3:0] MUL_LAST = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LAST = 4'(DIV_CYCLES - 1);

    state_e      state_q, state_d;
    commit_e     mode_q, mode_d;
    logic [3:0]  count_q, count_d;
    logic [63:0] pend_q, pend_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;

    logic [63:0] prod_s, prod_u;
    logic        div_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, dvd, dvs;
    logic [31:0] q_mag, r_mag, q_res, r_res;

    always_comb begin
        prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u = {32'd0, A} * {32'd0, B};
    end

    // One shared unsigned divider; signed ops divide magnitudes and fix signs after.
    always_comb begin
        div_signed = (MDUop == OP_DIV);
        a_neg      = div_signed & A[31];
        b_neg      = div_signed & B[31];
        a_mag      = a_neg ? (32'd0 - A) : A;
        b_mag      = b_neg ? (32'd0 - B) : B;
        dvd        = a_mag;
        dvs        = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag      = dvd / dvs;
        r_mag      = dvd % dvs;
        q_res      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        r_res      = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        count_d = count_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;

        if (state_q == S_IDLE) begin
            if (start) begin
                case (MDUop)
                    OP_MULT, OP_MULTU: begin
                        pend_d  = (MDUop == OP_MULT) ? prod_s : prod_u;
                        mode_d  = CM_LOAD;
                        count_d = MUL_LAST;
                        state_d = S_BUSY;
                        busy_d  = 1'b1;
                    end
                    OP_DIV, OP_DIVU: begin
                        pend_d  = {r_res, q_res};
                        mode_d  = (B == 32'd0) ? CM_SKIP : CM_LOAD;
                        count_d = DIV_LAST;
                        state_d = S_BUSY;
                        busy_d  = 1'b1;
                    end
                    OP_MTHI: hi_d = A;
                    OP_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
                    OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                        pend_d  = (MDUop == OP_MADD || MDUop == OP_MSUB) ? prod_s : prod_u;
                        mode_d  = (MDUop == OP_MADD || MDUop == OP_MADDU) ? CM_ADD : CM_SUB;
                        count_d = MUL_LAST;
                        state_d = S_BUSY;
                        busy_d  = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end else begin
            if (count_q == 4'd0) begin
                // Accumulate against {HI,LO} as they stand at commit, not at accept.
                case (mode_q)
                    CM_LOAD: {hi_d, lo_d} = pend_q;
                    CM_ADD:  {hi_d, lo_d} = {hi_q, lo_q} + pend_q;
                    CM_SUB:  {hi_d, lo_d} = {hi_q, lo_q} - pend_q;
                    default: ;
                endcase
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end else begin
                count_d = count_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= CM_LOAD;
            count_q <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
